fetch_unit: RTL

- Instruction-fetch stage directly downstream of the PC register.
- Takes the current PC, issues one instruction-bus request at a time, and handles the addr_ok/data_ok handshake.
- Writes the fetched instruction into the F/D pipeline register.
- Generates fetch_stall, which holds the PC register (drives its PCWrite) until the fetch completes; absorbs decode stalls and branch flushes.

---
 rtl/fetch_unit.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage sitting right after the PC register.
// Latches the PC, issues one instruction-bus request at a time, follows the
// addr_ok/data_ok handshake and writes the fetched instruction into the F/D
// pipeline register. fetch_stall holds the PC register until a fetch is
// delivered. Decode stalls are absorbed by a one-entry hold buffer, and
// flushes squash the fetch in flight.
//
// Optional build macro: FETCH_MISALIGN_EN
//   When defined, a PC with pc[1:0] != 0 is not sent to the bus. The block
//   completes with fd_instr=0 and raises fd_misalign alongside the F/D entry.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   pc                         current PC from the PC register
//   flush                      redirect/squash from execute
//   stall_d                    decode cannot accept a new F/D entry
//   ireq_valid, ireq_addr      instruction-bus request
//   iresp_addr_ok              bus accepted the request
//   iresp_data_ok, iresp_data  bus returned instruction data
//   fetch_stall                1 = PC register must hold
//   fd_valid, fd_pc, fd_instr  F/D pipeline register
//   fd_misalign                misaligned-PC marker (FETCH_MISALIGN_EN only)
module fetch_unit #(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned ADDR_W  = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               flush,
  input  logic               stall_d,
  output logic               ireq_valid,
  output logic [ADDR_W-1:0]  ireq_addr,
  input  logic               iresp_addr_ok,
  input  logic               iresp_data_ok,
  input  logic [INSTR_W-1:0] iresp_data,
  output logic               fetch_stall,
  output logic               fd_valid,
  output logic [ADDR_W-1:0]  fd_pc,
  output logic [INSTR_W-1:0] fd_instr
`ifdef FETCH_MISALIGN_EN
  ,
  output logic               fd_misalign
`endif
);

  // S_MISA is a bus-less completion cycle, only reachable with FETCH_MISALIGN_EN
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_MISA = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                drop_q, drop_d;
  logic [ADDR_W-1:0]   req_pc_q;
  logic [INSTR_W-1:0]  hold_q;
  logic                misaligned;
  logic                cmp;
  logic                fetch_done;
  logic                hold_load;
  logic [INSTR_W-1:0]  src_instr;

`ifdef FETCH_MISALIGN_EN
  logic                hold_mis_q;
  logic                src_mis;
  assign misaligned = (pc[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // Completion: data is available this cycle (bus data or the misaligned stub)
  assign cmp = ((state_q == S_REQ)  && iresp_addr_ok && iresp_data_ok) ||
               ((state_q == S_WAIT) && iresp_data_ok) ||
               (state_q == S_MISA);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (!flush) state_d = misaligned ? S_MISA : S_REQ;
      S_REQ:  if (iresp_addr_ok && !iresp_data_ok) state_d = S_WAIT;
      S_WAIT: state_d = S_WAIT;
      S_HOLD: if (flush || !stall_d) state_d = S_IDLE;
      S_MISA: state_d = S_MISA;
      default: state_d = S_IDLE;
    endcase
    // A squashed or deliverable completion returns to IDLE; a stalled one parks in HOLD
    if (cmp) state_d = (drop_q || flush || !stall_d) ? S_IDLE : S_HOLD;
  end

  // Output and datapath-control decode
  always_comb begin
    ireq_valid = (state_q == S_REQ);
    ireq_addr  = req_pc_q;
    fetch_done = 1'b0;
    hold_load  = 1'b0;
    src_instr  = (state_q == S_MISA) ? '0 : iresp_data;
    if (cmp && !drop_q && !flush) begin
      if (!stall_d) fetch_done = 1'b1;
      else          hold_load  = 1'b1;
    end
    if ((state_q == S_HOLD) && !flush && !stall_d) begin
      fetch_done = 1'b1;
      src_instr  = hold_q;
    end
    fetch_stall = !(fetch_done || flush);
    // drop remembers a flush that hit an in-flight request; it dies on return to IDLE
    if (state_d == S_IDLE) begin
      drop_d = 1'b0;
    end else if (((state_q == S_REQ) || (state_q == S_WAIT)) && flush) begin
      drop_d = 1'b1;
    end else begin
      drop_d = drop_q;
    end
  end

`ifdef FETCH_MISALIGN_EN
  assign src_mis = (state_q == S_MISA) || ((state_q == S_HOLD) && hold_mis_q);
`endif

  // Request latch, hold buffer and F/D register
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_q   <= 1'b0;
      req_pc_q <= '0;
      hold_q   <= '0;
      fd_valid <= 1'b0;
      fd_pc    <= '0;
      fd_instr <= '0;
    end else begin
      drop_q <= drop_d;
      if ((state_q == S_IDLE) && !flush) req_pc_q <= pc;
      if (hold_load) hold_q <= src_instr;
      if (flush) begin
        fd_valid <= 1'b0;
      end else if (fetch_done) begin
        fd_valid <= 1'b1;
        fd_pc    <= req_pc_q;
        fd_instr <= src_instr;
      end else if (!stall_d) begin
        fd_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_MISALIGN_EN
  // Misalign marker travels with the entry through the hold buffer
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_mis_q  <= 1'b0;
      fd_misalign <= 1'b0;
    end else begin
      if (hold_load) hold_mis_q <= (state_q == S_MISA);
      if (!flush && fetch_done) fd_misalign <= src_mis;
    end
  end
`endif

endmodule
